// File: rtl/lsu_ctrl.sv
// Load/store unit: word-aligned memory access, sub-word extraction and read-modify-write stores.
// Optional macro LSU_BOUNDS_CHECK_EN adds an address range check against BASE_ADDR/MEM_WORDS.
module lsu_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    output logic [2:0]  mem_read_o,
    output logic [2:0]  mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    localparam logic [2:0]  MEM_LW   = 3'b101;
    localparam logic [2:0]  MEM_SW   = 3'b100;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [31:0] addr_q, merge_q, rdata_q;
    logic [2:0]  f3_q;
    logic        we_q, fault_q;

    logic        accept, bad_align, bad_f3, oob, illegal;
    logic [4:0]  sh;
    logic [31:0] shifted, load_ext, lane_mask, lane_ins, merged;

    // ---------------- request legality ----------------
    always_comb begin
        bad_align = 1'b0;
        case (req_funct3_i[1:0])
            2'b01:   bad_align = req_addr_i[0];
            2'b10:   bad_align = (req_addr_i[1:0] != 2'b00);
            default: bad_align = 1'b0;
        endcase
    end

    assign bad_f3  = req_we_i ? (req_funct3_i >= 3'b011)
                              : (req_funct3_i == 3'b011 || req_funct3_i == 3'b110 ||
                                 req_funct3_i == 3'b111);
    assign oob     = ({1'b0, req_addr_i} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr_i} >= END_ADDR);
    assign illegal = bad_align || bad_f3 || (BOUNDS_EN && oob);
    assign accept  = req_valid_i && req_ready_o;

    // ---------------- lane extraction / insertion ----------------
    assign sh      = {addr_q[1:0], 3'b000};
    assign shifted = mem_rdata_i >> sh;

    always_comb begin
        load_ext = shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // merge_q still holds the right-aligned store data while in RMW_RD
    assign lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign lane_ins  = (merge_q & (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF)) << sh;
    assign merged    = (mem_rdata_i & ~lane_mask) | lane_ins;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        mem_read_o  = 3'b000;
        mem_write_o = 3'b000;
        rsp_valid_o = 1'b0;
        rsp_fault_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (illegal)                      state_nxt = RESP;
                    else if (!req_we_i)               state_nxt = LOAD;
                    else if (req_funct3_i == 3'b010)  state_nxt = STORE;
                    else                              state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                mem_read_o = rst ? 3'b000 : MEM_LW;
                state_nxt  = RESP;
            end
            RMW_RD: begin
                mem_read_o = rst ? 3'b000 : MEM_LW;
                state_nxt  = STORE;
            end
            STORE: begin
                mem_write_o = rst ? 3'b000 : MEM_SW;
                state_nxt   = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_fault_o = fault_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                f3_q    <= req_funct3_i;
                we_q    <= req_we_i;
                fault_q <= illegal;
                if (req_we_i && !illegal) merge_q <= req_wdata_i;
                if (illegal)              rdata_q <= '0;
            end
            if (state == RMW_RD) merge_q <= merged;
            // loads capture extended data; stores clear the response data
            if (state == LOAD || state == STORE) rdata_q <= we_q ? '0 : load_ext;
        end
    end

    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = merge_q;
    assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected responses, a monitor pops and compares.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [2:0]  mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_fault_o(rsp_fault),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // small aliased data memory: combinational read, write on clock edge
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b1;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899_AABB;
            mem[63] <= 32'h1357_9BDF;
        end else if (mem_write == 3'b100) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
                chk("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // issue one request; rd_m/wr_m bit k-1 = memory read/write expected in cycle k after acceptance
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int lat, input logic [3:0] rd_m,
                          input logic [3:0] wr_m, input logic [31:0] exp_wd);
        int t;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("ready_timeout", 32'(req_ready), 32'h1);
        e.rdata = exp_rdata; e.fault = exp_fault; e.lat = lat; e.acc = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_ready", 32'(req_ready), 32'h0);
            chk("mem_read", 32'(mem_read), rd_m[k-1] ? 32'h5 : 32'h0);
            chk("mem_write", 32'(mem_write), wr_m[k-1] ? 32'h4 : 32'h0);
            if (rd_m[k-1] || wr_m[k-1]) chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (wr_m[k-1]) chk("mem_wdata", mem_wdata, exp_wd);
        end
        t = 0;
        while (sb_q.size() != 0 && t < 10) begin @(negedge clk); t++; end
        if (sb_q.size() != 0) begin
            chk("rsp_timeout", 32'(sb_q.size()), 32'h0);
            sb_q.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fault", 32'(rsp_fault), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 1. sub-word loads from 0x8899AABB
        do_req(1'b0, 3'b000, 32'h8000_0011, 32'h0, 32'hFFFF_FFAA, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        @(negedge clk);
        chk("rdata_hold", rsp_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 3'b100, 32'h8000_0011, 32'h0, 32'h0000_00AA, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        do_req(1'b0, 3'b101, 32'h8000_0012, 32'h0, 32'h0000_8899, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        do_req(1'b0, 3'b001, 32'h8000_0012, 32'h0, 32'hFFFF_8899, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h8899_AABB, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);

        // 2. read-modify-write stores
        do_req(1'b1, 3'b000, 32'h8000_0012, 32'h0000_0012, 32'h0, 1'b0, 3, 4'b0001, 4'b0010, 32'h8812_AABB);
        do_req(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h8812_AABB, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        do_req(1'b1, 3'b001, 32'h8000_0010, 32'hFFFF_CAFE, 32'h0, 1'b0, 3, 4'b0001, 4'b0010, 32'h8812_CAFE);
        do_req(1'b0, 3'b000, 32'h8000_0013, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);

        // 3. misaligned / illegal: fault after one cycle, response data cleared
        do_req(1'b0, 3'b010, 32'h8000_0012, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b1, 3'b001, 32'h8000_0011, 32'h5555, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b0, 3'b111, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b1, 3'b011, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h8812_CAFE, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);

        // 4. full-word store then load
        do_req(1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 4'b0000, 4'b0001, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);

        // 5. reset while in STORE: no write, clean idle afterwards
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8000_0020; req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_write", 32'(mem_write), 32'h0);
        chk("rst_mid_read", 32'(mem_read), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_rdata", rsp_rdata, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);

        // 6. address range
`ifdef LSU_BOUNDS_CHECK_EN
        do_req(1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_8000, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_7FFC, 32'h0, 32'h1357_9BDF, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
`else
        do_req(1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h1357_9BDF, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
        do_req(1'b0, 3'b010, 32'h8000_8000, 32'h0, 32'h0000_0000, 1'b0, 2, 4'b0001, 4'b0000, 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
